// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync endpoint.
// Request/response layouts and endpoint FSM states.
package fractal_sync_pkg;

  localparam int unsigned AGGR_W = 1;
  localparam int unsigned ID_W   = 1;
  localparam int unsigned LVL_W  = 1;

  typedef struct packed {
    logic [AGGR_W-1:0] aggr;
    logic [ID_W-1:0]   id;
  } fsync_req_sig_t;

  typedef struct packed {
    logic           sync;
    fsync_req_sig_t sig;
  } fsync_req_t;

  typedef struct packed {
    logic [LVL_W-1:0] lvl;
    logic [ID_W-1:0]  id;
  } fsync_rsp_sig_t;

  typedef struct packed {
    logic           wake;
    logic           error;
    fsync_rsp_sig_t sig;
  } fsync_rsp_t;

  typedef enum logic [2:0] {
    EP_IDLE,
    EP_SEND,
    EP_WAIT,
    EP_DONE,
    EP_ERR
  } ep_state_e;

endpackage

// File: rtl/fractal_sync_ep_timer.sv
// Saturating WAIT-cycle counter for the sync endpoint.
// Flags the last allowed cycle before a timeout.
module fractal_sync_ep_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  // count enabled cycles, saturating at CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(CYCLES))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en & (cnt == W'(CYCLES - 1));

endmodule

// File: rtl/fractal_sync_endpoint.sv
// Leaf-side barrier requester for a fractal_sync_1d port.
// Keeps one barrier in flight and waits for its wake.
module fractal_sync_endpoint #(
  parameter int unsigned AGGREGATE_WIDTH = 1,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned LVL_WIDTH       = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter type fsync_req_t = fractal_sync_pkg::fsync_req_t,
  parameter type fsync_rsp_t = fractal_sync_pkg::fsync_rsp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bar_valid_i,
  output logic                       bar_ready_o,
  input  logic [AGGREGATE_WIDTH-1:0] bar_aggr_i,
  input  logic [ID_WIDTH-1:0]        bar_id_i,
  output logic                       done_o,
  output logic [LVL_WIDTH-1:0]       done_lvl_o,
  output logic                       error_o,
  output logic                       timeout_o,
  output logic                       spurious_o,
  input  logic                       clr_i,
  output logic                       busy_o,
  output fsync_req_t                 req_o,
  input  fsync_rsp_t                 rsp_i
);

  import fractal_sync_pkg::*;

  ep_state_e state_q;
  ep_state_e state_d;

  logic [AGGREGATE_WIDTH-1:0] aggr_q;
  logic [ID_WIDTH-1:0]        id_q;
  logic [LVL_WIDTH-1:0]       lvl_q;

  logic accept;
  logic in_wait;
  logic match;
  logic expired;
  logic enter_send;
  logic spur_set;
  logic tmo_set;

  assign bar_ready_o = (state_q == EP_IDLE) & ~rst_i;
  assign accept      = bar_ready_o & bar_valid_i;
  assign in_wait     = (state_q == EP_WAIT);
  assign match       = rsp_i.wake & (rsp_i.sig.id == id_q);
  assign enter_send  = accept & (bar_aggr_i != '0);

  assign spur_set = rsp_i.wake &
                    (~in_wait | (~match & ~rsp_i.error));
  assign tmo_set  = in_wait & ~rsp_i.error & ~match & expired;

  if (TIMEOUT_CYCLES != 0) begin : g_timer
    fractal_sync_ep_timer #(
      .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
      .clk     (clk_i),
      .rst     (rst_i),
      .clr     (enter_send),
      .en      (in_wait),
      .expired (expired)
    );
  end else begin : g_no_timer
    assign expired = 1'b0;
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EP_IDLE: begin
        if (accept) begin
          state_d = (bar_aggr_i != '0) ? EP_SEND : EP_ERR;
        end
      end
      EP_SEND: state_d = EP_WAIT;
      EP_WAIT: begin
        if (rsp_i.error) begin
          state_d = EP_ERR;
        end else if (match) begin
          state_d = EP_DONE;
        end else if (expired) begin
          state_d = EP_ERR;
        end
      end
      EP_DONE: state_d = EP_IDLE;
      EP_ERR:  state_d = EP_IDLE;
      default: state_d = EP_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // barrier command and wake level capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aggr_q <= '0;
      id_q   <= '0;
      lvl_q  <= '0;
    end else begin
      if (enter_send) begin
        aggr_q <= bar_aggr_i;
        id_q   <= bar_id_i;
      end
      if (in_wait && !rsp_i.error && match) begin
        lvl_q <= rsp_i.sig.lvl;
      end
    end
  end

  // sticky status flags; a new event beats clr_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spurious_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (spur_set) begin
        spurious_o <= 1'b1;
      end else if (clr_i) begin
        spurious_o <= 1'b0;
      end
      if (tmo_set) begin
        timeout_o <= 1'b1;
      end else if (clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

  // single-cycle request toward the tree node
  always_comb begin
    req_o = '0;
    if (state_q == EP_SEND) begin
      req_o.sync     = 1'b1;
      req_o.sig.aggr = aggr_q;
      req_o.sig.id   = id_q;
    end
  end

  assign done_o     = (state_q == EP_DONE);
  assign error_o    = (state_q == EP_ERR);
  assign busy_o     = (state_q != EP_IDLE);
  assign done_lvl_o = lvl_q;

endmodule

// File: tb/tb_fractal_sync_endpoint.sv
// Directed and randomized checks of fractal_sync_endpoint.
// Expected timing comes from a per-barrier event model.
module tb_fractal_sync_endpoint;

  typedef struct packed {
    logic [1:0] aggr;
    logic [2:0] id;
  } req_sig_t;

  typedef struct packed {
    logic     sync;
    req_sig_t sig;
  } req_t;

  typedef struct packed {
    logic [1:0] lvl;
    logic [2:0] id;
  } rsp_sig_t;

  typedef struct packed {
    logic     wake;
    logic     error;
    rsp_sig_t sig;
  } rsp_t;

  localparam int TMO = 8;

  logic       clk;
  logic       rst;
  logic       bar_valid;
  logic       bar_ready;
  logic [1:0] bar_aggr;
  logic [2:0] bar_id;
  logic       done;
  logic [1:0] done_lvl;
  logic       error;
  logic       timeout;
  logic       spurious;
  logic       clr;
  logic       busy;
  req_t       req;
  rsp_t       rsp;

  int tests = 0;
  int fails = 0;

  fractal_sync_endpoint #(
    .AGGREGATE_WIDTH (2),
    .ID_WIDTH        (3),
    .LVL_WIDTH       (2),
    .TIMEOUT_CYCLES  (TMO),
    .fsync_req_t     (req_t),
    .fsync_rsp_t     (rsp_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bar_valid_i (bar_valid),
    .bar_ready_o (bar_ready),
    .bar_aggr_i  (bar_aggr),
    .bar_id_i    (bar_id),
    .done_o      (done),
    .done_lvl_o  (done_lvl),
    .error_o     (error),
    .timeout_o   (timeout),
    .spurious_o  (spurious),
    .clr_i       (clr),
    .busy_o      (busy),
    .req_o       (req),
    .rsp_i       (rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] a,
                       input logic [2:0] i);
    bar_valid = 1'b1;
    bar_aggr  = a;
    bar_id    = i;
    step();
    bar_valid = 1'b0;
  endtask

  task automatic wake(input logic [2:0] i,
                      input logic [1:0] l,
                      input logic e);
    rsp          = '0;
    rsp.wake     = 1'b1;
    rsp.error    = e;
    rsp.sig.id   = i;
    rsp.sig.lvl  = l;
  endtask

  task automatic rand_barrier(input int n);
    logic [1:0] a;
    logic [2:0] i;
    logic [1:0] l;
    logic       e;
    int d;
    int nsync, sync_c, done_c, err_c;
    logic [1:0] s_aggr, s_lvl;
    logic [2:0] s_id;
    int x_sync, x_done, x_err;
    logic x_tmo;
    a = 2'($urandom_range(0, 3));
    i = 3'($urandom);
    l = 2'($urandom);
    e = ($urandom_range(0, 5) == 0);
    d = $urandom_range(0, 10);
    for (int g = $urandom_range(0, 2); g > 0; g--) step();
    nsync = 0; sync_c = -1; done_c = -1; err_c = -1;
    s_aggr = '0; s_id = '0; s_lvl = '0;
    issue(a, i);
    for (int c = 1; c <= 13; c++) begin
      if (req.sync) begin
        nsync++;
        sync_c = c;
        s_aggr = req.sig.aggr;
        s_id   = req.sig.id;
      end
      if (done) begin
        done_c = c;
        s_lvl  = done_lvl;
      end
      if (error) err_c = c;
      rsp = '0;
      if (a != 0 && d < TMO && c == 2 + d) wake(i, l, e);
      step();
    end
    rsp = '0;
    x_sync = (a != 0) ? 1 : 0;
    x_tmo  = (a != 0) && (d >= TMO);
    if (a == 0) begin
      x_done = -1;
      x_err  = 1;
    end else if (d >= TMO) begin
      x_done = -1;
      x_err  = TMO + 2;
    end else begin
      x_done = e ? -1 : 3 + d;
      x_err  = e ? 3 + d : -1;
    end
    chk($sformatf("r%0d_nsync", n), nsync, x_sync);
    if (x_sync == 1) begin
      chk($sformatf("r%0d_sync_c", n), sync_c, 1);
      chk($sformatf("r%0d_aggr", n), s_aggr, a);
      chk($sformatf("r%0d_id", n), s_id, i);
    end
    chk($sformatf("r%0d_done_c", n), done_c, x_done);
    if (x_done != -1)
      chk($sformatf("r%0d_lvl", n), s_lvl, l);
    chk($sformatf("r%0d_err_c", n), err_c, x_err);
    chk($sformatf("r%0d_tmo", n), timeout, x_tmo);
    chk($sformatf("r%0d_spur", n), spurious, 1'b0);
    chk($sformatf("r%0d_busy", n), busy, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic any_err;
    rst = 1'b1;
    bar_valid = 1'b0;
    bar_aggr = '0;
    bar_id = '0;
    clr = 1'b0;
    rsp = '0;
    #12;
    chk("rst_ready", bar_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", req, '0);
    chk("rst_flags", {done, error, timeout, spurious}, 4'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_ready", bar_ready, 1'b1);

    // 1: basic barrier
    issue(2'b01, 3'd3);
    chk("t1_sync", req.sync, 1'b1);
    chk("t1_aggr", req.sig.aggr, 2'b01);
    chk("t1_id", req.sig.id, 3'd3);
    step();
    chk("t1_sync_once", req, '0);
    step();
    step();
    step();
    wake(3'd3, 2'd1, 1'b0);
    step();
    rsp = '0;
    chk("t1_done", done, 1'b1);
    chk("t1_lvl", done_lvl, 2'd1);
    step();
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_lvl_hold", done_lvl, 2'd1);
    chk("t1_idle", busy, 1'b0);

    // 2: wrong-id wake, clr in the same cycle
    issue(2'b01, 3'd3);
    step();
    wake(3'd2, 2'd0, 1'b0);
    clr = 1'b1;
    step();
    rsp = '0;
    clr = 1'b0;
    chk("t2_spur", spurious, 1'b1);
    chk("t2_nodone", done, 1'b0);
    chk("t2_busy", busy, 1'b1);
    wake(3'd3, 2'd2, 1'b0);
    step();
    rsp = '0;
    chk("t2_done", done, 1'b1);
    chk("t2_lvl", done_lvl, 2'd2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t2_clr", spurious, 1'b0);

    // 3: timeout
    issue(2'b10, 3'd5);
    chk("t3_sync", req.sync, 1'b1);
    any_err = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      step();
      any_err |= error | timeout;
    end
    chk("t3_early", any_err, 1'b0);
    step();
    chk("t3_err", error, 1'b1);
    chk("t3_tmo", timeout, 1'b1);
    step();
    chk("t3_busy", busy, 1'b0);
    chk("t3_err_pulse", error, 1'b0);
    chk("t3_tmo_sticky", timeout, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_clr", timeout, 1'b0);

    // 4: zero aggregate
    chk("t4_ready", bar_ready, 1'b1);
    issue(2'b00, 3'd5);
    chk("t4_err", error, 1'b1);
    chk("t4_nosync", req.sync, 1'b0);
    step();
    chk("t4_err_pulse", error, 1'b0);
    chk("t4_idle", busy, 1'b0);

    // 5: error beats a matching wake
    issue(2'b10, 3'd4);
    step();
    wake(3'd4, 2'd2, 1'b1);
    step();
    rsp = '0;
    chk("t5_err", error, 1'b1);
    chk("t5_nodone", done, 1'b0);
    step();
    chk("t5_ready", bar_ready, 1'b1);
    chk("t5_spur", spurious, 1'b0);

    // 6: reset mid-barrier
    issue(2'b01, 3'd3);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", bar_ready, 1'b0);
    chk("t6_outs", {req.sync, done, error}, 3'b0);
    @(negedge clk);
    rst = 1'b0;
    wake(3'd3, 2'd1, 1'b0);
    step();
    rsp = '0;
    chk("t6_spur", spurious, 1'b1);
    chk("t6_nodone", done, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    issue(2'b11, 3'd6);
    chk("t6_sync", req.sync, 1'b1);
    step();
    wake(3'd6, 2'd3, 1'b0);
    step();
    rsp = '0;
    chk("t6_done", done, 1'b1);
    chk("t6_lvl", done_lvl, 2'd3);
    step();

    // randomized barriers
    for (int n = 0; n < 30; n++) rand_barrier(n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
